// File: rtl/alu_muldiv_sequencer_if.sv
// Bundle between the execute stage and the multiply/divide sequencer.
// The master side is the core plus the shared ALU: it issues requests and
// returns the ALU result. The slave side is the sequencer.
interface alu_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             AluOwn;
  logic [WIDTH-1:0] AluIn1;
  logic [WIDTH-1:0] AluIn2;
  logic [3:0]       AluOp;
  logic [WIDTH-1:0] AluOut;

  modport master (
    output Start, Op, A, B, AluOut,
    input  Busy, Done, HI, LO, AluOwn, AluIn1, AluIn2, AluOp
  );

  modport slave (
    input  Start, Op, A, B, AluOut,
    output Busy, Done, HI, LO, AluOwn, AluIn1, AluIn2, AluOp
  );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Unsigned MULTU/DIVU sequencer. Borrows the shared ALU for WIDTH add
// (shift-add multiply) or subtract (restoring divide) iterations and leaves
// the 2*WIDTH-bit result in HI/LO.
//
// state  | meaning
// IDLE   | waiting for Start, ALU released
// RUN    | iterating, owns the ALU, Busy = 1
// DONE   | one-cycle Done pulse, HI/LO valid, new Start accepted
module alu_muldiv_sequencer #(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] ADD_OP = 4'b0010,
  parameter logic [3:0] SUB_OP = 4'b0110
) (
  input logic                   clk,
  input logic                   reset,
  alu_muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_op;

  logic             w_run;
  logic [WIDTH-1:0] w_rem;
  logic             w_ovf;
  logic             w_carry;
  logic             w_ge;
  logic [WIDTH-1:0] w_alu_in1;
  logic [WIDTH-1:0] w_alu_in2;
  logic [3:0]       w_alu_op;

  assign w_run   = (r_state == S_RUN);
  // Partial remainder after shifting in the next dividend bit; the bit
  // shifted out of HI (ovf) means the remainder certainly exceeds B.
  assign w_rem   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_ovf   = r_hi[WIDTH-1];
  // The ALU drops its carry, so recover it from wrap-around.
  assign w_carry = (bus.AluOut < r_hi);
  assign w_ge    = w_ovf | (w_rem >= r_b);

  // ALU operand mux: driven only while running, parked at 0 + 0 otherwise
  always_comb begin
    w_alu_in1 = '0;
    w_alu_in2 = '0;
    w_alu_op  = ADD_OP;
    if (w_run) begin
      w_alu_in2 = r_b;
      if (r_op) begin
        w_alu_in1 = w_rem;
        w_alu_op  = SUB_OP;
      end else begin
        w_alu_in1 = r_hi;
      end
    end
  end

  assign bus.Busy   = w_run;
  assign bus.AluOwn = w_run;
  assign bus.Done   = (r_state == S_DONE);
  assign bus.HI     = r_hi;
  assign bus.LO     = r_lo;
  assign bus.AluIn1 = w_alu_in1;
  assign bus.AluIn2 = w_alu_in2;
  assign bus.AluOp  = w_alu_op;

  // Sequencer state, iteration counter and HI/LO datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_op) begin
            r_hi <= w_ge ? bus.AluOut : w_rem;
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else if (r_lo[0]) begin
            {r_hi, r_lo} <= {w_carry, bus.AluOut, r_lo[WIDTH-1:1]};
          end else begin
            {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
          end
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          if (bus.Start) begin
            r_op    <= bus.Op;
            r_b     <= bus.B;
            r_count <= '0;
            if (bus.Op && (bus.B == '0)) begin
              // Divide by zero resolves immediately without iterating.
              r_hi    <= bus.A;
              r_lo    <= '1;
              r_state <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= bus.A;
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer: directed corner cases plus
// random operations compared against plain 64-bit arithmetic.
module tb_alu_muldiv_sequencer;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_muldiv_sequencer_if #(.WIDTH(32)) bus ();

  alu_muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Shared ALU model: add or subtract, carry/borrow discarded.
  assign bus.AluOut = (bus.AluOp == SUB) ? (bus.AluIn1 - bus.AluIn2)
                                         : (bus.AluIn1 + bus.AluIn2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation at the current negedge and follow it to Done.
  // poke_at >= 0 pulses Start with junk operands after that many busy cycles.
  // chain = 1 returns in the Done cycle so the caller can start back-to-back.
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int poke_at, input bit chain, input string tag);
    logic [63:0] prod;
    logic [31:0] ehi, elo;
    int          n, busy_n;
    bit          bad_own, div0;
    div0 = op && (b == 32'd0);
    if (!op) begin
      prod = {32'd0, a} * {32'd0, b};
      ehi  = prod[63:32];
      elo  = prod[31:0];
    end else if (div0) begin
      ehi = a;
      elo = 32'hFFFF_FFFF;
    end else begin
      ehi = a % b;
      elo = a / b;
    end
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.Op = 1'($urandom_range(0, 1));
    chk({tag, "/first_busy"}, 64'(bus.Busy), 64'(!div0));
    n = 0; busy_n = 0; bad_own = 1'b0;
    while (!bus.Done && n < 40) begin
      if (bus.Busy) begin
        busy_n++;
        if (bus.AluOp !== (op ? SUB : ADD) || bus.AluOwn !== 1'b1) bad_own = 1'b1;
      end else begin
        bad_own = 1'b1;
      end
      bus.Start = (poke_at >= 0 && busy_n == poke_at);
      if (bus.Start) begin
        bus.A = $urandom; bus.B = $urandom; bus.Op = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    bus.Start = 1'b0;
    chk({tag, "/latency"}, 64'(n), div0 ? 64'd0 : 64'd32);
    chk({tag, "/busy_cycles"}, 64'(busy_n), div0 ? 64'd0 : 64'd32);
    chk({tag, "/aluop_run"}, 64'(bad_own), 64'd0);
    chk({tag, "/hi"}, 64'(bus.HI), 64'(ehi));
    chk({tag, "/lo"}, 64'(bus.LO), 64'(elo));
    chk({tag, "/own_in_done"}, 64'(bus.AluOwn), 64'd0);
    if (!chain) begin
      @(negedge clk);
      chk({tag, "/done_pulse"}, {62'd0, bus.Done, bus.Busy}, 64'd0);
      chk({tag, "/hold"}, {bus.HI, bus.LO}, {ehi, elo});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rop;
    bus.Start = 1'b0; bus.Op = 1'b0; bus.A = '0; bus.B = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset/busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
    chk("reset/hilo", {bus.HI, bus.LO}, 64'd0);
    chk("reset/own", 64'(bus.AluOwn), 64'd0);
    chk("idle/alu", {bus.AluIn1, bus.AluIn2}, 64'd0);
    chk("idle/aluop", 64'(bus.AluOp), 64'(ADD));
    reset = 1'b0;
    @(negedge clk);

    do_op(1'b0, 32'd7, 32'd6, -1, 1'b0, "mul_7x6");
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, "mul_max");
    do_op(1'b1, 32'd100, 32'd7, -1, 1'b0, "div_100_7_b2b");
    do_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, -1, 1'b0, "div_ovf");
    do_op(1'b1, 32'h1234, 32'd0, -1, 1'b0, "div_by_zero");
    do_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b0, "mul_start_ignored");
    do_op(1'b1, 32'hDEAD_BEEF, 32'h0000_1357, 10, 1'b1, "div_start_ignored");
    do_op(1'b1, 32'h55, 32'd0, -1, 1'b1, "div0_b2b");
    do_op(1'b0, 32'd11, 32'd13, -1, 1'b0, "mul_after_div0");

    bus.Start = 1'b1; bus.Op = 1'b0; bus.A = 32'd9; bus.B = 32'd9;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_reset/busy_before", 64'(bus.Busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset/busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
    chk("mid_reset/hilo", {bus.HI, bus.LO}, 64'd0);
    do_op(1'b0, 32'd3, 32'd5, -1, 1'b0, "mul_3x5_after_reset");

    for (int i = 0; i < 24; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 16));
        2: rb = 32'd0;
        default: rb = {1'b1, 31'($urandom)};
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      do_op(rop, ra, rb, -1, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
Multi-cycle controller that executes unsigned MULTU/DIVU by sequencing the shared 32-bit ALU through 32 add or subtract iterations. It owns the ALU input mux while busy and writes the 64-bit result into HI/LO. It sits beside the ALU in the execute stage. The core stalls on Busy and reads HI/LO after Done.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.
ADD_OP, 4'b0010, ALUOP code the block drives for an add.
SUB_OP, 4'b0110, ALUOP code the block drives for a subtract.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle request; sampled only when not Busy
Op  input  1  0 = MULTU, 1 = DIVU; sampled with Start
A  input  WIDTH  multiplicand / dividend; sampled with Start
B  input  WIDTH  multiplier / divisor; sampled with Start
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse; HI/LO valid from this cycle
HI  output  WIDTH  product[63:32] / remainder
LO  output  WIDTH  product[31:0] / quotient
AluOwn  output  1  selects the sequencer onto the ALU inputs; equals Busy
AluIn1  output  WIDTH  ALU operand 1
AluIn2  output  WIDTH  ALU operand 2
AluOp  output  4  ALU operation code
AluOut  input  WIDTH  ALU result; combinational, same cycle

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset; polarity and synchronicity are fixed.
- States: IDLE, RUN, DONE. The iteration counter is 5 bits.
- Reset (synchronous, overrides everything including mid-operation):
  - state = IDLE, count = 0.
  - Busy = Done = AluOwn = 0, HI = LO = 0.
  - Any in-flight operation is discarded.
- IDLE/DONE + Start = 1 (edge E0):
  - Latch Op and B.
  - MULTU: HI = 0, LO = A.
  - DIVU with B != 0: HI = 0, LO = A.
  - State goes to RUN, count = 0.
- IDLE/DONE + Start = 1 with DIVU and B == 0:
  - No RUN phase.
  - HI = A, LO = 32'hFFFFFFFF.
  - State goes to DONE, so Done = 1 in the next cycle.
- DONE lasts exactly one cycle. With no Start it returns to IDLE. Start in DONE is accepted as a new operation (back-to-back).
- Start while in RUN is ignored. A, B and Op changes during RUN have no effect.
- Busy = 1 exactly while in RUN. Done = 1 exactly while in DONE.
- RUN, MULTU (edges E1..E32):
  - AluIn1 = HI, AluIn2 = B (latched), AluOp = ADD_OP.
  - carry = (AluOut < HI), unsigned compare done inside the block; the ALU drops the carry.
  - If LO[0] = 1: {HI, LO} <= {carry, AluOut, LO[31:1]}.
  - Else: {HI, LO} <= {1'b0, HI, LO[31:1]}.
- RUN, DIVU (restoring division):
  - R' = {HI[30:0], LO[31]}, ovf = HI[31].
  - AluIn1 = R', AluIn2 = B, AluOp = SUB_OP.
  - ge = ovf | (R' >= B), unsigned compare done inside the block.
  - If ge: HI <= AluOut, else HI <= R'.
  - LO <= {LO[30:0], ge}.
- Completion and latency:
  - The iteration at edge E32 (count == 31) moves the state to DONE.
  - Done is high in the cycle after E32, i.e. 33 cycles after the Start cycle.
- HI/LO hold their final value until the next accepted Start or reset.
- When not Busy:
  - AluIn1 = AluIn2 = 0, AluOp = ADD_OP.
  - These are don't-care to the core because AluOwn = 0.
- Arithmetic:
  - All compares are unsigned.
  - Products are exact 64-bit results.
  - Quotient/remainder satisfy A = LO*B + HI with HI < B.

Test Plan:
- MULTU: Start with A = 7, B = 6 -> Busy for 32 cycles, Done one cycle later, HI = 0, LO = 42; AluOp = 4'b0010 throughout RUN.
- MULTU: A = B = 32'hFFFFFFFF -> HI = 32'hFFFFFFFE, LO = 32'h00000001 (exercises carry).
- DIVU: A = 100, B = 7 -> LO = 14, HI = 2, AluOp = 4'b0110 during RUN. Also A = 32'hFFFFFFFF, B = 32'h80000001 -> LO = 1, HI = 32'h7FFFFFFE (exercises ovf).
- DIVU: B = 0, A = 32'h1234 -> Busy never asserts, Done in the next cycle, HI = 32'h1234, LO = 32'hFFFFFFFF.
- Start pulsed with different A/B at RUN cycle 10 -> ignored; original result unchanged. Start asserted during Done -> new op begins with no idle cycle; Busy the next cycle.
- reset held one cycle at RUN cycle 20 -> next cycle Busy = Done = 0, HI = LO = 0, state IDLE. A subsequent 3 * 5 completes correctly with LO = 15.
